// File: rtl/radix4_ifft_seq_pkg.sv
// Shared definitions for the radix-4 transform blocks (forward and inverse).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//   Contents: FSM state encoding, default component width, output scale shift.
package radix4_ifft_seq_pkg;

  // Default signed width of each real/imag component.
  localparam int DW_DEF = 8;

  // Right shift applied to the butterfly sums, which divides the result by 4.
  localparam int SCALE_SH = 2;

  // The frame FSM. The encodings are fixed so both transform directions agree.
  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_EMIT    = 2'd2
  } state_e;

endpackage

// File: rtl/radix4_ibutterfly.sv
// Purpose: combinational 4-point inverse DFT butterfly. The outputs are not scaled.
// Latency: 0 cycles (pure combinational logic).
// Backpressure: none. The caller registers the outputs.
//   Ports: x_re/x_im[0..3] hold the DW-bit input bins X[k].
//          y_re/y_im[0..3] hold the DW+2-bit sums x[n]*4.
module radix4_ibutterfly
  import radix4_ifft_seq_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic signed [DW-1:0] x_re [4],
  input  logic signed [DW-1:0] x_im [4],
  output logic signed [DW+1:0] y_re [4],
  output logic signed [DW+1:0] y_im [4]
);

  // Sign-extended copies of the inputs. Four DW-bit terms always fit in DW+2 bits.
  logic signed [DW+1:0] a [4];
  logic signed [DW+1:0] b [4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      a[k] = {{2{x_re[k][DW-1]}}, x_re[k]};
      b[k] = {{2{x_im[k][DW-1]}}, x_im[k]};
    end
  end

  // Multiplying by j maps (a,b) to (-b,a). Multiplying by -j maps (a,b) to (b,-a).
  always_comb begin
    // x0 = X0 + X1 + X2 + X3
    y_re[0] = a[0] + a[1] + a[2] + a[3];
    y_im[0] = b[0] + b[1] + b[2] + b[3];
    // x1 = X0 + jX1 - X2 - jX3
    y_re[1] = a[0] - b[1] - a[2] + b[3];
    y_im[1] = b[0] + a[1] - b[2] - a[3];
    // x2 = X0 - X1 + X2 - X3
    y_re[2] = a[0] - a[1] + a[2] - a[3];
    y_im[2] = b[0] - b[1] + b[2] - b[3];
    // x3 = X0 - jX1 - X2 + jX3
    y_re[3] = a[0] + b[1] - a[2] - b[3];
    y_im[3] = b[0] - a[1] - b[2] + a[3];
  end

endmodule

// File: rtl/radix4_ifft_seq.sv
// Purpose: sequential 4-point inverse FFT. It collects 4 bins, computes x[n] = (1/4)*sum X[k]*(+j)^(n*k), then emits 4 samples.
// Latency: after the 4th input handshake there is one COMPUTE cycle, then the first output is valid.
// Backpressure: in_ready is high only while collecting. The output holds stable while out_valid && !out_ready.
//   Ports: clk, rst_n (synchronous, active-low)
//          in_valid/in_ready/in_re/in_im/in_last carry the input bin stream
//          out_valid/out_ready/out_re/out_im/out_idx/out_last carry the output sample stream
//          frame_err pulses for one cycle when a malformed frame is dropped
module radix4_ifft_seq
  import radix4_ifft_seq_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic [1:0]           out_idx,
  output logic                 out_last,
  output logic                 frame_err
);

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic signed [DW-1:0] buf_re_q [4];
  logic signed [DW-1:0] buf_re_d [4];
  logic signed [DW-1:0] buf_im_q [4];
  logic signed [DW-1:0] buf_im_d [4];
  logic signed [DW-1:0] res_re_q [4];
  logic signed [DW-1:0] res_re_d [4];
  logic signed [DW-1:0] res_im_q [4];
  logic signed [DW-1:0] res_im_d [4];
  logic [1:0]           idx_q, idx_d;
  logic                 ovld_q, ovld_d;
  logic                 ferr_q, ferr_d;

  logic signed [DW+1:0] bf_re [4];
  logic signed [DW+1:0] bf_im [4];

  radix4_ibutterfly #(.DW(DW)) u_bfly (
    .x_re (buf_re_q),
    .x_im (buf_im_q),
    .y_re (bf_re),
    .y_im (bf_im)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_re_d = buf_re_q;
    buf_im_d = buf_im_q;
    res_re_d = res_re_q;
    res_im_d = res_im_q;
    idx_d    = idx_q;
    ovld_d   = ovld_q;
    ferr_d   = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (in_valid) begin
          buf_re_d[cnt_q] = in_re;
          buf_im_d[cnt_q] = in_im;
          if (cnt_q == 2'd3 && in_last) begin
            state_d = ST_COMPUTE;
            cnt_d   = 2'd0;
          end else if (cnt_q == 2'd3 || in_last) begin
            // Either the last marker came early or it is missing on the 4th bin.
            // Drop the frame and restart collection.
            cnt_d  = 2'd0;
            ferr_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      ST_COMPUTE: begin
        // The floor shift always brings the DW+2-bit sum back into DW bits,
        // so the truncation cannot lose any significant bits.
        for (int k = 0; k < 4; k++) begin
          res_re_d[k] = DW'(bf_re[k] >>> SCALE_SH);
          res_im_d[k] = DW'(bf_im[k] >>> SCALE_SH);
        end
        state_d = ST_EMIT;
        idx_d   = 2'd0;
        ovld_d  = 1'b1;
      end

      ST_EMIT: begin
        if (out_ready) begin
          // The index wraps from 3 back to 0, ready for the next frame.
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            ovld_d  = 1'b0;
            state_d = ST_COLLECT;
          end
        end
      end

      default: begin
        state_d = ST_COLLECT;
        cnt_d   = 2'd0;
        ovld_d  = 1'b0;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      cnt_q   <= 2'd0;
      idx_q   <= 2'd0;
      ovld_q  <= 1'b0;
      ferr_q  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        buf_re_q[k] <= '0;
        buf_im_q[k] <= '0;
        res_re_q[k] <= '0;
        res_im_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ovld_q   <= ovld_d;
      ferr_q   <= ferr_d;
      buf_re_q <= buf_re_d;
      buf_im_q <= buf_im_d;
      res_re_q <= res_re_d;
      res_im_q <= res_im_d;
    end
  end

  assign in_ready  = (state_q == ST_COLLECT);
  assign out_valid = ovld_q;
  assign out_idx   = idx_q;
  assign out_last  = (idx_q == 2'd3);
  // The result registers are cleared on reset, so out_re/out_im read 0 after reset.
  assign out_re    = res_re_q[idx_q];
  assign out_im    = res_im_q[idx_q];
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_radix4_ifft_seq.sv
module tb_radix4_ifft_seq;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_re;
  logic signed [7:0] in_im;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_re;
  logic signed [7:0] out_im;
  logic [1:0]        out_idx;
  logic              out_last;
  logic              frame_err;

  always #5 clk = ~clk;

  radix4_ifft_seq #(.DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int xr [4];
  int xi [4];
  int er [4];
  int ei [4];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int floor_div4(input int s);
    int r;
    r = s % 4;
    if (r < 0) r += 4;
    return (s - r) / 4;
  endfunction

  // Reference model: x[n] = floor((1/4) * sum_k X[k] * j^(n*k)).
  task automatic model();
    for (int n = 0; n < 4; n++) begin
      int sr;
      int si;
      sr = 0;
      si = 0;
      for (int k = 0; k < 4; k++) begin
        case ((n * k) % 4)
          0: begin sr += xr[k]; si += xi[k]; end
          1: begin sr -= xi[k]; si += xr[k]; end
          2: begin sr -= xr[k]; si -= xi[k]; end
          default: begin sr += xi[k]; si -= xr[k]; end
        endcase
      end
      er[n] = floor_div4(sr);
      ei[n] = floor_div4(si);
    end
  endtask

  task automatic set_bins(input int r0, input int i0, input int r1, input int i1,
                          input int r2, input int i2, input int r3, input int i3);
    xr[0] = r0; xi[0] = i0; xr[1] = r1; xi[1] = i1;
    xr[2] = r2; xi[2] = i2; xr[3] = r3; xi[3] = i3;
    model();
  endtask

  task automatic rand_bins();
    for (int k = 0; k < 4; k++) begin
      xr[k] = int'($urandom_range(0, 255)) - 128;
      xi[k] = int'($urandom_range(0, 255)) - 128;
    end
    model();
  endtask

  // Called at a negedge. Returns at the negedge that follows the handshake edge.
  task automatic send_bin(input int re, input int im, input bit last);
    int w;
    in_valid = 1'b1;
    in_re    = re[7:0];
    in_im    = im[7:0];
    in_last  = last;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("in_ready_timeout", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame();
    for (int k = 0; k < 4; k++) send_bin(xr[k], xi[k], k == 3);
    chk("no_valid_right_after_last_bin", int'(out_valid), 0);
    chk("in_ready_low_after_last_bin", int'(in_ready), 0);
  endtask

  task automatic recv_frame(input int stall_idx, input int stall_n, input int n_take);
    int w;
    for (int n = 0; n < n_take; n++) begin
      w = 0;
      while (!out_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("out_valid", int'(out_valid), 1);
      chk("out_idx", int'(out_idx), n);
      chk("out_re", int'(out_re), er[n]);
      chk("out_im", int'(out_im), ei[n]);
      chk("out_last", int'(out_last), (n == 3) ? 1 : 0);
      chk("in_ready_low_in_emit", int'(in_ready), 0);
      if (n == stall_idx && stall_n > 0) begin
        out_ready = 1'b0;
        repeat (stall_n) begin
          @(negedge clk);
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_idx", int'(out_idx), n);
          chk("hold_re", int'(out_re), er[n]);
          chk("hold_im", int'(out_im), ei[n]);
          chk("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    if (n_take == 4) begin
      chk("valid_drops_after_last", int'(out_valid), 0);
      chk("in_ready_after_last_out", int'(in_ready), 1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_re", int'(out_re), 0);
    chk("rst_out_im", int'(out_im), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Impulse
    set_bins(4, 0, 0, 0, 0, 0, 0, 0);
    send_frame();
    recv_frame(-1, 0, 4);

    // Single bin at k=1
    set_bins(0, 0, 4, 0, 0, 0, 0, 0);
    send_frame();
    recv_frame(-1, 0, 4);

    // Rounding toward minus infinity
    set_bins(-1, 0, 0, 0, 0, 0, 0, 0);
    send_frame();
    recv_frame(-1, 0, 4);

    // Full scale
    set_bins(127, -128, 127, -128, 127, -128, 127, -128);
    send_frame();
    recv_frame(-1, 0, 4);

    // Backpressure: 3 stall cycles at idx 1
    rand_bins();
    send_frame();
    recv_frame(1, 3, 4);

    // Malformed: in_last on the 2nd bin
    send_bin(5, 6, 1'b0);
    send_bin(7, 8, 1'b1);
    chk("ferr_early_last", int'(frame_err), 1);
    @(negedge clk);
    chk("ferr_one_cycle", int'(frame_err), 0);
    chk("no_output_after_drop", int'(out_valid), 0);
    chk("in_ready_after_drop", int'(in_ready), 1);

    // Malformed: the 4th bin has no last marker
    for (int k = 0; k < 3; k++) send_bin(k, -k, 1'b0);
    chk("no_ferr_midframe", int'(frame_err), 0);
    send_bin(3, 3, 1'b0);
    chk("ferr_missing_last", int'(frame_err), 1);
    @(negedge clk);
    chk("ferr_one_cycle_2", int'(frame_err), 0);
    chk("no_output_after_drop_2", int'(out_valid), 0);

    // A well-formed impulse frame recovers correctly
    set_bins(4, 0, 0, 0, 0, 0, 0, 0);
    send_frame();
    recv_frame(-1, 0, 4);

    // Reset in mid-EMIT, after idx 1 has been accepted
    rand_bins();
    send_frame();
    recv_frame(-1, 0, 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_idx", int'(out_idx), 0);
    chk("midrst_frame_err", int'(frame_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    rand_bins();
    send_frame();
    recv_frame(-1, 0, 4);

    // Random frames with random backpressure
    for (int f = 0; f < 16; f++) begin
      rand_bins();
      send_frame();
      recv_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
